// File: rtl/uart_baud_ctrl_pkg.sv
// Shared types, supported baud constants and helpers for the baud controller.
package uart_baud_ctrl_pkg;

  typedef logic [16:0] baud_t;
  typedef logic [17:0] cnt_t;

  localparam baud_t BAUD_4800   = 17'd4800;
  localparam baud_t BAUD_9600   = 17'd9600;
  localparam baud_t BAUD_14400  = 17'd14400;
  localparam baud_t BAUD_19200  = 17'd19200;
  localparam baud_t BAUD_38400  = 17'd38400;
  localparam baud_t BAUD_57600  = 17'd57600;
  localparam baud_t BAUD_115200 = 17'd115200;
  localparam baud_t BAUD_128000 = 17'd128000;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNSUP = 2'd1;
  localparam logic [1:0] ERR_DRAIN = 2'd2;
  localparam logic [1:0] ERR_LOCK  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RESET,
    LOCK,
    REVERT
  } baud_ctrl_state_t;

  function automatic logic is_supported_baud(baud_t baud);
    case (baud)
      BAUD_4800, BAUD_9600, BAUD_14400, BAUD_19200,
      BAUD_38400, BAUD_57600, BAUD_115200, BAUD_128000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(cnt_t c);
    return (c == '1) ? c : c + 18'd1;
  endfunction

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Host-side configuration port of the baud controller.
//
// Handshake: a request transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. The host holds cfg_baud stable while cfg_valid is
// high and cfg_ready is low; cfg_ready is high only while the controller is
// idle and requests are never queued. Each accepted request ends with exactly
// one single-cycle pulse of cfg_done or cfg_err; err_code is valid with
// cfg_err and holds until the next request is accepted.
interface uart_baud_ctrl_if;
  import uart_baud_ctrl_pkg::*;

  logic       cfg_valid;
  baud_t      cfg_baud;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;
  logic [1:0] err_code;

  modport master (
    output cfg_valid, cfg_baud,
    input  cfg_ready, cfg_done, cfg_err, err_code
  );

  modport slave (
    input  cfg_valid, cfg_baud,
    output cfg_ready, cfg_done, cfg_err, err_code
  );

endinterface

// File: rtl/uart_baud_ctrl.sv
// Runtime baud-rate controller: drains the link, re-syncs the tick generator,
// confirms both ticks resume, and falls back to the last good rate otherwise.
module uart_baud_ctrl
  import uart_baud_ctrl_pkg::*;
#(
  parameter int DEFAULT_BAUD  = 9600,
  parameter int RST_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT = 200000,
  parameter int LOCK_TIMEOUT  = 16384
) (
  input  logic             clk,
  input  logic             rst,
  uart_baud_ctrl_if.slave  cfg,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             link_hold,
  output baud_t            gen_baud,
  output logic             gen_rst,
  input  logic             gen_tx_tick,
  input  logic             gen_rx_tick,
  output baud_t            cur_baud,
  output baud_ctrl_state_t state
);

  localparam baud_t DEF_BAUD  = baud_t'(DEFAULT_BAUD);
  localparam cnt_t  RST_LAST  = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t  DRAIN_LIM = cnt_t'(DRAIN_TIMEOUT);
  localparam cnt_t  LOCK_LIM  = cnt_t'(LOCK_TIMEOUT);
  // The generator's internal max registers need two cycles after reset.
  localparam cnt_t  SETTLE    = 18'd2;

  baud_ctrl_state_t state_n;
  cnt_t       cnt, cnt_n, cnt_inc;
  baud_t      new_baud, new_baud_n, gen_baud_n, cur_baud_n;
  logic       gen_rst_n;
  logic       done_q, done_n, err_q, err_n;
  logic [1:0] err_code_q, err_code_n;
  logic       tx_seen, tx_seen_n, rx_seen, rx_seen_n;
  logic       settled;

  assign cnt_inc   = sat_inc(cnt);
  assign settled   = (cnt >= SETTLE);
  assign link_hold = (state != IDLE);

  assign cfg.cfg_ready = (state == IDLE);
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign cfg.err_code  = err_code_q;

  // State and datapath registers; reset forces every output to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      new_baud   <= DEF_BAUD;
      gen_baud   <= DEF_BAUD;
      cur_baud   <= DEF_BAUD;
      gen_rst    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      tx_seen    <= 1'b0;
      rx_seen    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      new_baud   <= new_baud_n;
      gen_baud   <= gen_baud_n;
      cur_baud   <= cur_baud_n;
      gen_rst    <= gen_rst_n;
      done_q     <= done_n;
      err_q      <= err_n;
      err_code_q <= err_code_n;
      tx_seen    <= tx_seen_n;
      rx_seen    <= rx_seen_n;
    end
  end

  // Next-state logic; the single cycle counter restarts on every state change.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt_inc;
    new_baud_n = new_baud;
    gen_baud_n = gen_baud;
    cur_baud_n = cur_baud;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code_q;
    tx_seen_n  = tx_seen;
    rx_seen_n  = rx_seen;

    unique case (state)
      IDLE: begin
        cnt_n     = '0;
        tx_seen_n = 1'b0;
        rx_seen_n = 1'b0;
        if (cfg.cfg_valid) begin
          new_baud_n = cfg.cfg_baud;
          err_code_n = ERR_NONE;
          if (!is_supported_baud(cfg.cfg_baud)) begin
            err_n      = 1'b1;
            err_code_n = ERR_UNSUP;
          end else if (cfg.cfg_baud == cur_baud) begin
            done_n = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy && !rx_busy) begin
          state_n    = RESET;
          cnt_n      = '0;
          gen_baud_n = new_baud;
        end else if (cnt_inc >= DRAIN_LIM) begin
          state_n    = IDLE;
          err_n      = 1'b1;
          err_code_n = ERR_DRAIN;
        end
      end
      RESET: begin
        if (cnt == RST_LAST) begin
          state_n = LOCK;
          cnt_n   = '0;
        end
      end
      LOCK: begin
        tx_seen_n = tx_seen | (settled & gen_tx_tick);
        rx_seen_n = rx_seen | (settled & gen_rx_tick);
        // Success is checked first so a lock on the timeout cycle still commits.
        if (tx_seen_n && rx_seen_n) begin
          state_n    = IDLE;
          cur_baud_n = new_baud;
          done_n     = 1'b1;
        end else if (cnt_inc >= LOCK_LIM) begin
          state_n    = REVERT;
          cnt_n      = '0;
          gen_baud_n = cur_baud;
        end
      end
      REVERT: begin
        if (cnt == RST_LAST) begin
          state_n    = IDLE;
          err_n      = 1'b1;
          err_code_n = ERR_LOCK;
        end
      end
      default: state_n = IDLE;
    endcase

    gen_rst_n = (state_n == RESET) || (state_n == REVERT);
  end

endmodule
